// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner and its
// debounce FSM.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        HELD
    } kp_state_t;

    // Scan result: bit 4 set means no key seen, otherwise [3:0] is {col, row}.
    localparam logic [4:0] SCAN_NONE = 5'h10;

    // Hex legend of each key, indexed by {col, row}; index 0 is the top-left key.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hC, 4'hB, 4'hA,
        4'hE, 4'h9, 4'h6, 4'h3,
        4'hF, 4'h8, 4'h5, 4'h2,
        4'h0, 4'h7, 4'h4, 4'h1
    };

    // Lowest-numbered active-low row; only meaningful when some row is low.
    function automatic logic [1:0] first_low(input logic [3:0] r);
        first_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) first_low = 2'(i);
        end
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce FSM: turns one scan result per full keypad scan into accepted key
// presses and releases. KEYPAD_REPEAT_EN adds periodic re-strobing while held.
module keypad_debounce #(
    parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_SCANS   = 64
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done,
    input  logic [4:0] scan_res,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    import keypad_pkg::*;

    localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_SCANS - 1);

    kp_state_t       state;
    logic [3:0]      cand;
    logic [3:0]      held_idx;
    logic [DB_W-1:0] match_cnt;
    logic [DB_W-1:0] rel_cnt;
    logic            res_none;
    logic [3:0]      res_idx;

    assign res_none = scan_res[4];
    assign res_idx  = scan_res[3:0];

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
    logic [REP_W-1:0] rep_cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cand      <= '0;
            held_idx  <= '0;
            match_cnt <= '0;
            rel_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (!res_none) begin
                            cand      <= res_idx;
                            match_cnt <= DB_W'(1);
                            state     <= CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        if (res_none) begin
                            match_cnt <= '0;
                            state     <= IDLE;
                        end else if (res_idx == cand) begin
                            if (match_cnt == DB_LAST) begin
                                key_code  <= KEY_MAP[cand];
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                held_idx  <= cand;
                                match_cnt <= '0;
                                rel_cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= '0;
`endif
                                state     <= HELD;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            cand      <= res_idx;
                            match_cnt <= DB_W'(1);
                        end
                    end
                    HELD: begin
                        if (res_none) begin
                            match_cnt <= '0;
                            if (rel_cnt == DB_LAST) begin
                                rel_cnt  <= '0;
                                key_held <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                rel_cnt <= rel_cnt + 1'b1;
                            end
                        end else if (res_idx == held_idx) begin
                            rel_cnt   <= '0;
                            match_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (rep_cnt == REP_LAST) begin
                                rep_cnt   <= '0;
                                key_valid <= 1'b1;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
`endif
                        end else begin
                            // A different key while one is held: debounce it as a rolling press.
                            rel_cnt <= '0;
                            if (match_cnt != '0 && res_idx == cand) begin
                                if (match_cnt == DB_LAST) begin
                                    key_code  <= KEY_MAP[cand];
                                    key_valid <= 1'b1;
                                    held_idx  <= cand;
                                    match_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                                    rep_cnt   <= '0;
`endif
                                end else begin
                                    match_cnt <= match_cnt + 1'b1;
                                end
                            end else begin
                                cand      <= res_idx;
                                match_cnt <= DB_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates active-low columns, samples synchronised rows
// and feeds one result per full scan to the debouncer. Option: KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    import keypad_pkg::*;

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 2 || REPEAT_SCANS < 1) begin : g_bad_params
        $error("keypad_scanner: SCAN_DIV >= 4, DEBOUNCE_SCANS >= 2, REPEAT_SCANS >= 1 required");
    end

    logic [3:0]       row_p0;
    logic [3:0]       row_p1;
    logic [CNT_W-1:0] dwell_cnt;
    logic [1:0]       col_idx;
    logic             found;
    logic [3:0]       found_idx;
    logic             scan_done;
    logic [4:0]       scan_res;
    logic             dwell_end;
    logic             row_hit;
    logic [1:0]       row_sel;

    assign dwell_end = (dwell_cnt == DWELL_LAST);
    assign row_hit   = (row_p1 != 4'hF);
    assign row_sel   = first_low(row_p1);

    // Rows idle high through the pull-ups, so the synchroniser resets to all ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_p0 <= 4'hF;
            row_p1 <= 4'hF;
        end else begin
            row_p0 <= row;
            row_p1 <= row_p0;
        end
    end

    // Sample on the last dwell cycle; the first hit of a scan wins until column 3 closes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
            col       <= 4'b1110;
            found     <= 1'b0;
            found_idx <= '0;
            scan_done <= 1'b0;
            scan_res  <= SCAN_NONE;
        end else begin
            scan_done <= 1'b0;
            if (dwell_end) begin
                dwell_cnt <= '0;
                col_idx   <= col_idx + 2'd1;
                col       <= {col[2:0], col[3]};
                if (col_idx == 2'd3) begin
                    scan_done <= 1'b1;
                    found     <= 1'b0;
                    if (found) begin
                        scan_res <= {1'b0, found_idx};
                    end else if (row_hit) begin
                        scan_res <= {1'b0, col_idx, row_sel};
                    end else begin
                        scan_res <= SCAN_NONE;
                    end
                end else if (!found && row_hit) begin
                    found     <= 1'b1;
                    found_idx <= {col_idx, row_sel};
                end
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_SCANS   (REPEAT_SCANS)
`endif
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .scan_done (scan_done),
        .scan_res  (scan_res),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

endmodule
